// File: rtl/sample_fifo_pkg.sv
// Shared helpers for the sample FIFO controller: constant clog2 and the
// legality check for the external RAM read latency.
package sample_fifo_pkg;

  // Supported RAM port B read latencies (output register off / on).
  localparam int unsigned RD_LATENCY_NOREG = 1;
  localparam int unsigned RD_LATENCY_REG   = 2;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned pow;
    result = 0;
    pow    = 1;
    while (pow < value) begin
      pow    = pow << 1;
      result = result + 1;
    end
    return result;
  endfunction

  function automatic bit rd_latency_legal(input int unsigned lat);
    return (lat == RD_LATENCY_NOREG) || (lat == RD_LATENCY_REG);
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sample_fifo_obuf.sv
// Small register FIFO that holds samples returned from the RAM until the
// consumer takes them. Head is always visible; push and pop may coincide.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of indices and count
//   push/push_data : write one entry (caller guarantees space)
//   pop        : drop the head entry (caller guarantees count != 0)
//   head       : current head entry
//   count      : number of valid entries
module sample_fifo_obuf
  import sample_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] cnt;

  // Index increment with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Indices and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_idx <= idx_inc(wr_idx);
      if (pop)  rd_idx <= idx_inc(rd_idx);
      if (push && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Storage; reset to zero so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_idx] <= push_data;
    end
  end

  assign head  = mem[rd_idx];
  assign count = cnt;

endmodule

// File: rtl/sample_fifo_ctrl.sv
// First-word-fall-through sample FIFO built around an external simple
// dual-port RAM (port A write, port B read with 1- or 2-cycle latency).
// Holds the pointers, read credit logic, return-tag shift register and
// flags; returned RAM data lands in a small prefetch buffer so the consumer
// can take one sample per cycle.
//   clk_i, rst_n_i, flush_i      : clock, async active-low reset, sync clear
//   s_data_i/s_valid_i/s_ready_o : producer side
//   m_data_o/m_valid_o/m_ready_i : consumer side
//   level_o, afull_o, ovf_o      : occupancy, almost-full, sticky overflow
//   ram_wr_*_o                   : RAM port A
//   ram_rd_addr_o, ram_rd_data_i : RAM port B
module sample_fifo_ctrl
  import sample_fifo_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH   = 16384,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned AFULL_THRESH = ADDR_DEPTH - 16,
  parameter int unsigned ADDR_WIDTH   = clog2(ADDR_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [ADDR_WIDTH+1:0] level_o,
  output logic                  afull_o,
  output logic                  ovf_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

  localparam int unsigned PTR_W      = ADDR_WIDTH + 1;
  localparam int unsigned LVL_W      = ADDR_WIDTH + 2;
  localparam int unsigned OBUF_DEPTH = RD_LATENCY + 1;
  localparam int unsigned OCNT_W     = clog2(OBUF_DEPTH + 1);
  localparam int unsigned CRD_W      = OCNT_W + 1;

  // Elaboration-time parameter guards.
  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_rd_latency
    $error("sample_fifo_ctrl: RD_LATENCY must be 1 or 2");
  end
  if (!is_pow2(ADDR_DEPTH) || (ADDR_DEPTH < 4)) begin : g_bad_depth
    $error("sample_fifo_ctrl: ADDR_DEPTH must be a power of two >= 4");
  end

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      ram_cnt;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  fill;
  logic [RD_LATENCY-1:0] tag_sr;
  logic [OCNT_W-1:0]     inflight;
  logic [OCNT_W-1:0]     obuf_cnt;
  logic [CRD_W-1:0]      credit_used;
  logic [LVL_W-1:0]      level_nxt;
  logic [LVL_W-1:0]      level_q;
  logic                  afull_q;
  logic                  ovf_q;

  assign ram_cnt = wr_ptr - rd_ptr;
  assign full    = (ram_cnt == PTR_W'(ADDR_DEPTH));

  // Push is masked by reset so the RAM never sees a write while held in reset.
  assign push = s_valid_i & ~full & ~flush_i & rst_n_i;
  assign pop  = m_valid_o & m_ready_i & ~flush_i;
  assign fill = tag_sr[RD_LATENCY-1] & ~flush_i;

  // Reads currently travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight = inflight + OCNT_W'(tag_sr[i]);
    end
  end

  // Prefetch credit: a slot being popped this cycle may already be reissued,
  // which is what lets the steady state run at one sample per cycle.
  assign credit_used = CRD_W'(inflight) + CRD_W'(obuf_cnt) - CRD_W'(pop);
  assign issue       = (ram_cnt != '0) & (credit_used < CRD_W'(OBUF_DEPTH)) & ~flush_i;

  assign level_nxt = LVL_W'(ram_cnt) + LVL_W'(inflight) + LVL_W'(obuf_cnt);

  // Pointers, return tags and flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_sr  <= '0;
      level_q <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_sr  <= '0;
      level_q <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      tag_sr  <= (tag_sr << 1) | RD_LATENCY'(issue);
      level_q <= level_nxt;
      afull_q <= (level_nxt >= LVL_W'(AFULL_THRESH));
      if (s_valid_i && full) ovf_q <= 1'b1;
    end
  end

  sample_fifo_obuf #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CNT_W (OCNT_W)
  ) u_obuf (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .flush     (flush_i),
    .push      (fill),
    .push_data (ram_rd_data_i),
    .pop       (pop),
    .head      (m_data_o),
    .count     (obuf_cnt)
  );

  assign s_ready_o     = ~full;
  assign m_valid_o     = (obuf_cnt != '0);
  assign level_o       = level_q;
  assign afull_o       = afull_q;
  assign ovf_o         = ovf_q;
  assign ram_wr_en_o   = push;
  assign ram_wr_addr_o = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data_o = s_data_i;
  assign ram_rd_addr_o = rd_ptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_sample_fifo_ctrl.sv
// Bench for sample_fifo_ctrl with a behavioural dual-port RAM whose read
// latency follows RD_LATENCY. Expected samples are queued when accepted and
// compared when popped; occupancy and flags are tracked by a small model.
module tb_sample_fifo_ctrl;

  localparam int unsigned ADDR_DEPTH   = 16;
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned RD_LATENCY   = 2;
  localparam int unsigned AFULL_THRESH = 12;
  localparam int unsigned ADDR_WIDTH   = 4;
  localparam int unsigned LVL_W        = ADDR_WIDTH + 2;
  localparam int unsigned OBUF_DEPTH   = RD_LATENCY + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [LVL_W-1:0]      level;
  logic                  afull;
  logic                  ovf;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  always #5 clk = ~clk;

  sample_fifo_ctrl #(
    .ADDR_DEPTH   (ADDR_DEPTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .RD_LATENCY   (RD_LATENCY),
    .AFULL_THRESH (AFULL_THRESH)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .flush_i       (flush),
    .s_data_i      (s_data),
    .s_valid_i     (s_valid),
    .s_ready_o     (s_ready),
    .m_data_o      (m_data),
    .m_valid_o     (m_valid),
    .m_ready_i     (m_ready),
    .level_o       (level),
    .afull_o       (afull),
    .ovf_o         (ovf),
    .ram_wr_en_o   (ram_wr_en),
    .ram_wr_addr_o (ram_wr_addr),
    .ram_wr_data_o (ram_wr_data),
    .ram_rd_addr_o (ram_rd_addr),
    .ram_rd_data_i (ram_rd_data)
  );

  // Simple dual-port RAM: write port A, read port B with optional output register.
  logic [DATA_WIDTH-1:0] ram_mem [ADDR_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q1;
  logic [DATA_WIDTH-1:0] ram_q2;
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
    ram_q1 <= ram_mem[ram_rd_addr];
    ram_q2 <= ram_q1;
  end
  assign ram_rd_data = (RD_LATENCY == 2) ? ram_q2 : ram_q1;

  logic [DATA_WIDTH-1:0] exp_q [$];
  int   held;
  logic exp_ovf;
  int   n_tests;
  int   n_fail;

  // One clock of stimulus, starting and ending 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [DATA_WIDTH-1:0] d,
                      input logic r, input logic f);
    logic                  acc;
    logic                  pp;
    logic                  exp_af;
    logic [DATA_WIDTH-1:0] e;
    s_valid = v;
    s_data  = d;
    m_ready = r;
    flush   = f;
    #1;
    acc = v && s_ready && !f;
    pp  = m_valid && r && !f;
    if (acc) exp_q.push_back(d);
    if (pp) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got sample %08h, required no output", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %08h, required %08h", m_data, e);
        end
      end
    end
    if (v && !s_ready && !f) exp_ovf = 1'b1;
    @(posedge clk);
    #1;
    if (f) begin
      held = 0;
      exp_q.delete();
      exp_ovf = 1'b0;
    end
    exp_af = (held >= int'(AFULL_THRESH));
    n_tests++;
    if (level !== LVL_W'(held)) begin
      n_fail++;
      $display("FAIL level: got %0d, required %0d", level, held);
    end
    n_tests++;
    if (afull !== exp_af) begin
      n_fail++;
      $display("FAIL afull: got %b, required %b (level model %0d)", afull, exp_af, held);
    end
    n_tests++;
    if (ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL ovf: got %b, required %b", ovf, exp_ovf);
    end
    if (!f) held = held + int'(acc) - int'(pp);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      step(1'b0, '0, 1'b1, 1'b0);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d samples outstanding, required 0", exp_q.size());
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: m_valid %b, required 0", m_valid);
    end
  endtask

  task automatic apply_reset();
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    flush   = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    held    = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (m_valid !== 1'b0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_head: got valid %b data %08h, required 0 / 00000000", m_valid, m_data);
    end
    n_tests++;
    if (level !== '0 || afull !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got level %0d afull %b ovf %b, required 0 0 0", level, afull, ovf);
    end
    n_tests++;
    if (s_ready !== 1'b1 || ram_wr_en !== 1'b0 || ram_wr_addr !== '0 || ram_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_ram: got s_ready %b wr_en %b wr_addr %0d rd_addr %0d, required 1 0 0 0",
               s_ready, ram_wr_en, ram_wr_addr, ram_rd_addr);
    end
  endtask

  task automatic test_fall_through();
    step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ft_e0: m_valid %b, required 0", m_valid);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (m_valid !== 1'b0 || level !== LVL_W'(1)) begin
      n_fail++;
      $display("FAIL ft_e1: m_valid %b level %0d, required 0 / 1", m_valid, level);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ft_e2: m_valid %b, required 0", m_valid);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL ft_e3: m_valid %b data %08h, required 1 / a5a50001", m_valid, m_data);
    end
    drain();
  endtask

  task automatic test_streaming();
    int outs;
    int gaps;
    int k;
    logic started;
    outs = 0;
    gaps = 0;
    k = 0;
    started = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (m_valid) begin
        started = 1'b1;
        outs++;
      end else if (started) begin
        gaps++;
      end
      step(1'b1, DATA_WIDTH'(i), 1'b1, 1'b0);
    end
    while (outs < 1000 && k < 50) begin
      if (m_valid) outs++;
      else gaps++;
      step(1'b0, '0, 1'b1, 1'b0);
      k++;
    end
    n_tests++;
    if (outs != 1000 || gaps != 0) begin
      n_fail++;
      $display("FAIL stream_rate: got %0d outputs %0d gaps, required 1000 / 0", outs, gaps);
    end
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_ovf: got %b, required 0", ovf);
    end
    drain();
  endtask

  task automatic test_fill_full();
    int acc_n;
    acc_n = 0;
    for (int i = 0; i < 25; i++) begin
      if (s_ready) acc_n++;
      step(1'b1, 32'h0000_0100 + DATA_WIDTH'(i), 1'b0, 1'b0);
    end
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (acc_n != int'(ADDR_DEPTH + OBUF_DEPTH)) begin
      n_fail++;
      $display("FAIL full_accepted: got %0d, required %0d", acc_n, ADDR_DEPTH + OBUF_DEPTH);
    end
    n_tests++;
    if (level !== LVL_W'(19) || s_ready !== 1'b0 || ovf !== 1'b1 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_state: got level %0d s_ready %b ovf %b m_valid %b, required 19 0 1 1",
               level, s_ready, ovf, m_valid);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_release: s_ready %b after one pop, required 1", s_ready);
    end
    drain();
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    int pushed;
    int cyc;
    logic v;
    logic r;
    logic [DATA_WIDTH-1:0] d;
    pushed = 0;
    cyc = 0;
    while (pushed < int'(10 * ADDR_DEPTH) && cyc < 3000) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = $urandom;
      if (v && s_ready) pushed++;
      step(v, d, r, 1'b0);
      cyc++;
    end
    n_tests++;
    if (pushed < int'(10 * ADDR_DEPTH)) begin
      n_fail++;
      $display("FAIL wrap_progress: pushed %0d, required %0d", pushed, 10 * ADDR_DEPTH);
    end
    drain();
  endtask

  task automatic test_flush();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h1111_0001, 1'b0, 1'b0);
    step(1'b1, 32'h1111_0002, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Both reads are in flight here; flush together with a push.
    step(1'b1, 32'h1111_0003, 1'b1, 1'b1);
    n_tests++;
    if (level !== '0 || m_valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: got level %0d m_valid %b ovf %b, required 0 0 0", level, m_valid, ovf);
    end
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (m_valid !== 1'b0 || level !== '0) begin
      n_fail++;
      $display("FAIL flush_stale: got m_valid %b level %0d, required 0 / 0", m_valid, level);
    end
    step(1'b1, 32'h2222_0004, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'hC000_0000 + DATA_WIDTH'(i), 1'b1, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (m_valid !== 1'b0 || m_data !== '0 || level !== '0 || afull !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_out: got valid %b data %08h level %0d afull %b ovf %b, required 0 0 0 0 0",
               m_valid, m_data, level, afull, ovf);
    end
    n_tests++;
    if (s_ready !== 1'b1 || ram_wr_en !== 1'b0 || ram_wr_addr !== '0 || ram_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL areset_ram: got s_ready %b wr_en %b wr_addr %0d rd_addr %0d, required 1 0 0 0",
               s_ready, ram_wr_en, ram_wr_addr, ram_rd_addr);
    end
    s_valid = 1'b0;
    exp_q.delete();
    held    = 0;
    exp_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
    drain();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    held    = 0;
    exp_ovf = 1'b0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    test_reset();
    test_fall_through();
    test_streaming();
    test_fill_full();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
